// File: rtl/io_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : io_hex_display
// Brief    : Binary-to-decimal (double dabble) converter driving eight
//            active-low seven-segment displays from the CPU output register.
// Revision : 1.0 - initial release
// ============================================================================
module io_hex_display #(
    parameter int WIDTH         = 32,
    parameter int DIGITS        = 8,
    parameter int BLANK_LEADING = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_data,
    output logic             busy,
    output logic             overflow,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX6,
    output logic [6:0]       HEX7
);

    localparam int NBCD = (WIDTH * 30103) / 100000 + 1;
    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNTW-1:0] c_last_iter = CNTW'(WIDTH - 1);
    localparam logic [6:0]      c_seg_blank = 7'h7F;
    localparam logic [6:0]      c_seg_zero  = 7'h40;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_conv  = 2'd1;
    localparam logic [1:0] c_st_latch = 2'd2;

    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_shift;
    logic [4*NBCD-1:0]      r_bcd;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_pending;
    logic [WIDTH-1:0]       r_pend_data;
    logic                   r_overflow;
    logic [6:0]             r_disp [DIGITS];

    logic [4*NBCD-1:0]       w_bcd_adj;
    logic [4*NBCD+WIDTH-1:0] w_next;
    logic                    w_ovf;
    logic                    w_any_nz;
    logic [6:0]              w_disp [DIGITS];
    logic [6:0]              w_hex  [8];

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < NBCD; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // The top bit of the adjusted BCD falls off the shift; NBCD is sized so it is always zero.
    assign w_next = {w_bcd_adj, r_shift} << 1;

    generate
        if (NBCD > DIGITS) begin : g_ovf
            assign w_ovf = |r_bcd[4*NBCD-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    // Walk from the most significant displayed digit down, tracking whether any digit so far was nonzero.
    always_comb begin
        w_any_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_any_nz = w_any_nz | (r_bcd[4*k +: 4] != 4'd0);
            if ((BLANK_LEADING != 0) && !w_ovf && (k != 0) && !w_any_nz) begin
                w_disp[k] = c_seg_blank;
            end else begin
                w_disp[k] = f_seg(r_bcd[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_pend_data <= '0;
            r_overflow  <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                r_disp[k] <= ((k == 0) || (BLANK_LEADING == 0)) ? c_seg_zero : c_seg_blank;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (io_we) begin
                        r_shift   <= io_data;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                        r_state   <= c_st_conv;
                    end else if (r_pending) begin
                        r_shift   <= r_pend_data;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                        r_state   <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    {r_bcd, r_shift} <= w_next;
                    r_cnt            <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= c_st_latch;
                    end
                    if (io_we) begin
                        r_pending   <= 1'b1;
                        r_pend_data <= io_data;
                    end
                end
                c_st_latch: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        r_disp[k] <= w_disp[k];
                    end
                    r_overflow <= w_ovf;
                    r_state    <= c_st_idle;
                    if (io_we) begin
                        r_pending   <= 1'b1;
                        r_pend_data <= io_data;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < 8; k++) begin : g_hex
            if (k < DIGITS) begin : g_live
                assign w_hex[k] = r_disp[k];
            end else begin : g_blank
                assign w_hex[k] = c_seg_blank;
            end
        end
    endgenerate

    assign HEX0     = w_hex[0];
    assign HEX1     = w_hex[1];
    assign HEX2     = w_hex[2];
    assign HEX3     = w_hex[3];
    assign HEX4     = w_hex[4];
    assign HEX5     = w_hex[5];
    assign HEX6     = w_hex[6];
    assign HEX7     = w_hex[7];
    assign overflow = r_overflow;
    assign busy     = (r_state != c_st_idle) | r_pending;

endmodule
`default_nettype wire

// File: tb/tb_io_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_hex_display
// Brief    : Scoreboard bench for io_hex_display, blanking and non-blanking
//            instances driven in parallel from one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_hex_display;

    localparam int    c_width = 32;
    localparam int    c_maxe  = 8192;
    localparam longint c_lim  = 64'd100000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_we = 1'b0;
    logic [31:0] io_data = '0;

    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [55:0] hex_a, hex_b;

    io_hex_display #(.WIDTH(32), .DIGITS(8), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst(rst), .io_we(io_we), .io_data(io_data),
        .busy(busy_a), .overflow(ovf_a),
        .HEX0(hex_a[6:0]),   .HEX1(hex_a[13:7]),  .HEX2(hex_a[20:14]), .HEX3(hex_a[27:21]),
        .HEX4(hex_a[34:28]), .HEX5(hex_a[41:35]), .HEX6(hex_a[48:42]), .HEX7(hex_a[55:49])
    );

    io_hex_display #(.WIDTH(32), .DIGITS(8), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst(rst), .io_we(io_we), .io_data(io_data),
        .busy(busy_b), .overflow(ovf_b),
        .HEX0(hex_b[6:0]),   .HEX1(hex_b[13:7]),  .HEX2(hex_b[20:14]), .HEX3(hex_b[27:21]),
        .HEX4(hex_b[34:28]), .HEX5(hex_b[41:35]), .HEX6(hex_b[48:42]), .HEX7(hex_b[55:49])
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     at;
    } exp_t;

    exp_t sb[$];
    bit   exp_busy [c_maxe];
    bit   rst_edge [c_maxe];
    int   cyc = 0;
    bit   done = 1'b0;
    int   ntests = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'h40;  1: seg_of = 7'h79;  2: seg_of = 7'h24;  3: seg_of = 7'h30;
            4: seg_of = 7'h19;  5: seg_of = 7'h12;  6: seg_of = 7'h02;  7: seg_of = 7'h78;
            8: seg_of = 7'h00;  9: seg_of = 7'h10;  default: seg_of = 7'h7F;
        endcase
    endfunction

    // Decimal rendering straight from arithmetic on the value.
    function automatic logic [55:0] exp_hex(input bit is_rst, input longint v, input bit blank);
        longint p = 1;
        bit     ovf = !is_rst && (v >= c_lim);
        logic [55:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            if (is_rst) begin
                r[7*k +: 7] = (k == 0 || !blank) ? 7'h40 : 7'h7F;
            end else if (k > 0 && blank && !ovf && v < p) begin
                r[7*k +: 7] = 7'h7F;
            end else begin
                r[7*k +: 7] = seg_of(int'((v / p) % 10));
            end
            p = p * 10;
        end
        return r;
    endfunction

    // Monitor: samples 1 time unit after each edge, retires expected displays as they come due.
    bit     have_state = 1'b0;
    bit     cur_rst = 1'b1;
    longint cur_val = 0;

    always @(posedge clk) begin
        int e;
        logic [55:0] ea, eb;
        bit eo;
        #1;
        e = cyc - 1;
        if (e >= 0 && e < c_maxe) begin
            if (rst_edge[e]) begin
                sb.delete();
                cur_rst    = 1'b1;
                have_state = 1'b1;
            end
            while (sb.size() > 0 && sb[0].at <= e) begin
                exp_t x;
                x = sb.pop_front();
                cur_rst = 1'b0;
                cur_val = x.val;
            end
            if (have_state) begin
                ea = exp_hex(cur_rst, cur_val, 1'b1);
                eb = exp_hex(cur_rst, cur_val, 1'b0);
                eo = !cur_rst && (cur_val >= c_lim);
                ntests += 6;
                if (hex_a !== ea) begin
                    nfail++; $display("FAIL hex_blank edge %0d: got %h want %h", e, hex_a, ea);
                end
                if (hex_b !== eb) begin
                    nfail++; $display("FAIL hex_noblank edge %0d: got %h want %h", e, hex_b, eb);
                end
                if (ovf_a !== eo) begin
                    nfail++; $display("FAIL ovf_blank edge %0d: got %b want %b", e, ovf_a, eo);
                end
                if (ovf_b !== eo) begin
                    nfail++; $display("FAIL ovf_noblank edge %0d: got %b want %b", e, ovf_b, eo);
                end
                if (busy_a !== exp_busy[e]) begin
                    nfail++; $display("FAIL busy_blank edge %0d: got %b want %b", e, busy_a, exp_busy[e]);
                end
                if (busy_b !== exp_busy[e]) begin
                    nfail++; $display("FAIL busy_noblank edge %0d: got %b want %b", e, busy_b, exp_busy[e]);
                end
            end
        end
        if (done) begin
            ntests++;
            if (sb.size() != 0 || !have_state) begin
                nfail++;
                $display("FAIL drain: got %0d outstanding displays want 0", sb.size());
            end
            $display("[TB] %0d tests run, %0d failed", ntests, nfail);
            $finish;
        end
    end

    // Timeline model: a conversion started at edge s latches at s+WIDTH+1; one pending slot.
    bit     m_active = 1'b0;
    int     m_latch = 0;
    bit     m_pend = 1'b0;
    longint m_pend_val = 0;

    task automatic start_conv(input longint v, input int n);
        m_active = 1'b1;
        m_latch  = n + c_width + 1;
        sb.push_back('{val: v, at: m_latch});
    endtask

    task automatic step(input bit r, input bit we, input logic [31:0] d);
        int n;
        bit idle;
        @(negedge clk);
        rst = r; io_we = we; io_data = d;
        n = cyc;
        if (r) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
        end else begin
            idle = !m_active || (n > m_latch);
            if (idle && we) begin
                start_conv(longint'(d), n);
                m_pend = 1'b0;
            end else if (idle && m_pend) begin
                start_conv(m_pend_val, n);
                m_pend = 1'b0;
            end else if (!idle && we) begin
                m_pend     = 1'b1;
                m_pend_val = longint'(d);
            end
        end
        if (n < c_maxe) begin
            rst_edge[n] = r;
            exp_busy[n] = r ? 1'b0 : ((m_active && n < m_latch) || m_pend);
        end
    endtask

    task automatic idle_cycles(input int c);
        for (int i = 0; i < c; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    task automatic write(input logic [31:0] d);
        step(1'b0, 1'b1, d);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
        idle_cycles(3);
        write(32'd12345);              idle_cycles(40);
        write(32'hFFFF_FFFF);          idle_cycles(40);
        write(32'd1);                  idle_cycles(9);
        write(32'd7);                  idle_cycles(4);
        write(32'd99999999);           idle_cycles(80);
        write(32'd555);                idle_cycles(14);
        step(1'b1, 1'b0, 32'd0);       idle_cycles(50);
        write(32'd0);                  idle_cycles(40);
        write(32'd100000000);          idle_cycles(40);
        write(32'd99999999);           idle_cycles(32);
        write(32'd100000000);          idle_cycles(1);
        write(32'd10);                 idle_cycles(80);
        for (int i = 0; i < 500; i++) begin
            logic [31:0] v;
            v = $urandom;
            case ($urandom_range(0, 3))
                0: v = v % 1000;
                1: v = v % 100000000;
                2: v = 32'd99999999 + $urandom_range(0, 2);
                default: ;
            endcase
            if ($urandom_range(0, 249) == 0) step(1'b1, 1'b0, 32'd0);
            else if ($urandom_range(0, 5) == 0) write(v);
            else idle_cycles(1);
        end
        idle_cycles(80);
        @(negedge clk);
        done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no summary want summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/io_hex_display.md
# io_hex_display

Sequential output-side peripheral for the CPU's output IO register, the counterpart of the switch-driven input register. It accepts a 32-bit value on each CPU write strobe and converts it from binary to decimal by iterative shift-and-add-3 (double dabble), one bit per cycle. It then drives the eight active-low seven-segment displays HEX0..HEX7, with optional leading-zero blanking and an overflow flag. It sits between the CPU's io2_out/write strobe and the board's HEX pins in `top`.

## Interface
- `WIDTH`, default 32: binary input width; internal BCD digit count NBCD = (WIDTH*30103)/100000 + 1 (10 for 32).
- `DIGITS`, default 8: number of displays driven; must be ≤ NBCD.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros above HEX0; 0 shows all digits.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `io_we` input 1: one-cycle write strobe from the CPU for the output IO register.
- `io_data` input WIDTH: value written, sampled when `io_we`=1.
- `busy` output 1: conversion in progress or pending.
- `overflow` output 1: last displayed value ≥ 10^DIGITS.
- `HEX0`..`HEX7` output 7 each: active-low segments {g,f,e,d,c,b,a}; HEX0 is the least significant digit.

## Operation
- Segment codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, blank=7'h7F.
- **FSM states:** IDLE, CONV, LATCH.
- **IDLE**
  - If `io_we`: load the shift register with `io_data`, clear BCD, set bit counter to 0, go to CONV. A new write has priority over pending and clears pending.
  - Else if pending: load from the pending register, clear pending, go to CONV.
- **CONV**, once per cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then shift {BCD, shift register} left by one.
  - Counter increments; after iteration WIDTH-1, go to LATCH.
- **LATCH**
  - Register segment codes for digits 0..DIGITS-1 into the HEX outputs.
  - `overflow` = OR of nonzero digits DIGITS..NBCD-1.
  - Go to IDLE.
- **Leading-zero blanking** (BLANK_LEADING=1): digit k>0 is blank if it and all higher displayed digits are zero. HEX0 is never blanked. Overflow disables blanking; all DIGITS are shown.
- HEX outputs with index ≥ DIGITS are constant blank.
- **Write while not IDLE:** `io_data` is stored in the pending register and pending is set. Last write wins; earlier pending values are dropped. The conversion in flight completes undisturbed.
- `busy` = (state ≠ IDLE) | pending.
- **Reset:**
  - State IDLE, pending 0, `busy` 0, `overflow` 0.
  - HEX0=7'h40.
  - HEX1..HEX(DIGITS-1) = 7'h7F if BLANK_LEADING else 7'h40.
  - Reset mid-conversion discards all in-flight and pending data.

## Timing
- `io_we` sampled at edge E0 (state IDLE) → `busy`=1 after E0.
- CONV iterations run at edges E1..E_WIDTH.
- LATCH at edge E_WIDTH+1 updates HEX/`overflow`; `busy` falls after it (if nothing pending).
- Latency write→display: WIDTH+1 cycles (33 for default).
- HEX holds the previous value throughout conversion; no intermediate values are visible.
- **Pending restart:** pending present at LATCH → IDLE for one cycle → CONV next. Back-to-back conversion period is WIDTH+2 cycles.
- **`io_we` in the same cycle as LATCH:** captured into pending; converted next.
- All outputs are registered; no combinational path from `io_data` to HEX.

## Test plan
- **Reset only:** after reset, HEX0=7'h40, HEX1..7=7'h7F, `busy`=0, `overflow`=0.
- **Single write of 12345:**
  - `busy` high for exactly 33 cycles.
  - Then HEX0=7'h12, HEX1=7'h19, HEX2=7'h30, HEX3=7'h24, HEX4=7'h79, HEX5..7=7'h7F, `overflow`=0.
- **Overflow, write 0xFFFFFFFF (4294967295):**
  - `overflow`=1, no blanking.
  - HEX7..HEX0 = 9,4,9,6,7,2,9,5 (7'h10,7'h19,7'h10,7'h02,7'h78,7'h24,7'h10,7'h12).
- **Last write wins:**
  - Write 1, then 10 cycles later write 7, then 5 cycles later write 99999999.
  - HEX shows 1, then 99999999 (all 7'h10), with `overflow`=0.
  - 7 is never displayed.
  - `busy` is continuous until the second LATCH.
- **Reset mid-conversion:**
  - Write 555, assert `rst` at cycle 15.
  - Outputs return to reset values and `busy`=0.
  - No later display of 555.
- **BLANK_LEADING=0, write 0:** all eight HEX=7'h40 after 33 cycles. Then write 100000000 → `overflow`=1, HEX all 7'h40.
